// File: rtl/a_sqrt_b_pkg.sv
// a_sqrt_b_pkg: shared widths, cycle counts and FSM state type for the
// y = a * sqrt(b) compute core.
package a_sqrt_b_pkg;

  localparam int A_W      = 8;
  localparam int B_W      = 8;
  localparam int ROOT_W   = 5;            // 4-bit root plus rounding carry
  localparam int Y_W      = 12;
  localparam int SQRT_CYC = 4;
  localparam int MUL_CYC  = 5;

  localparam int SQ_W  = B_W / 2;         // bits produced by the 8-bit root
  localparam int ACC_W = A_W + ROOT_W;    // 13-bit shift-add accumulator
  localparam int CNT_W = 3;               // covers max(SQRT_CYC, MUL_CYC)

  typedef enum logic [1:0] {
    IDLE,
    SQRT,
    MUL
  } state_t;

endpackage

// File: rtl/a_sqrt_b_isqrt8.sv
// isqrt8: iterative 8-bit integer square root, bit-by-bit restoring method.
// 'start' loads the radicand and clears root/remainder; each 'step' consumes
// two radicand bits (MSB first) and produces one root bit. The root/rem
// outputs show the value as of the end of the current cycle, so the step in
// progress is already folded in and the caller can act on the final root at
// the same edge that computes it.
module isqrt8
  import a_sqrt_b_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [B_W-1:0]   rad_in,
  output logic [SQ_W-1:0]  root,
  output logic [B_W-1:0]   rem
);

  logic [B_W-1:0]  rad_q;
  logic [SQ_W-1:0] root_q;
  logic [B_W-1:0]  rem_q;

  logic [B_W-1:0]  rem_sh;
  logic [B_W-1:0]  trial;
  logic [B_W-1:0]  rem_step;
  logic [SQ_W-1:0] root_step;

  // One restoring iteration: bring down two bits, try subtracting 4r+1.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rem_sh    = (rem_q << 2) | {{(B_W-2){1'b0}}, rad_q[B_W-1 -: 2]};
    trial     = {{(B_W-SQ_W-2){1'b0}}, root_q, 2'b01};
    rem_step  = rem_sh;
    root_step = {root_q[SQ_W-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_step  = rem_sh - trial;
      root_step = {root_q[SQ_W-2:0], 1'b1};
    end
  end

  // Present the post-step view while stepping, the held value otherwise.
  always_comb begin
    root = root_q;
    rem  = rem_q;
    if (step) begin
      root = root_step;
      rem  = rem_step;
    end
  end

  // Radicand shift register, partial root and remainder.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (start) begin
      rad_q  <= rad_in;
      root_q <= '0;
      rem_q  <= '0;
    end else if (step) begin
      rad_q  <= {rad_q[B_W-3:0], 2'b00};
      root_q <= root_step;
      rem_q  <= rem_step;
    end
  end

endmodule

// File: rtl/a_sqrt_b.sv
// a_sqrt_b: multi-cycle y = a * sqrt(b), 8-bit operands, 12-bit result.
// Sequence: IDLE -> SQRT (4 cycles, root MSB first) -> MUL (5 cycles,
// shift-add, root LSB first) -> IDLE, with a one-cycle y_ready pulse on the
// last MUL edge. Fixed latency of 9 cycles from the accepting edge.
// Build option: define A_SQRT_B_ROUND_EN for a round-to-nearest root
// (r+1 when b > r*r + r); undefined gives the floor root.
module a_sqrt_b
  import a_sqrt_b_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a_in,
  input  logic [B_W-1:0] b_in,
  input  logic           in_ready,
  output logic [Y_W-1:0] y_out,
  output logic           y_ready
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  mcand_q;   // a, shifted left once per MUL step
  logic [ROOT_W-1:0] root_q;    // root, shifted right once per MUL step
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_nxt;

  logic sq_start;
  logic sq_step;
  logic last_sqrt;
  logic last_mul;

  logic [SQ_W-1:0]   sq_root;
  logic [B_W-1:0]    sq_rem;
  logic [ROOT_W-1:0] root_rnd;

  isqrt8 u_isqrt8 (
    .clk    (clk),
    .rst    (rst),
    .start  (sq_start),
    .step   (sq_step),
    .rad_in (b_in),
    .root   (sq_root),
    .rem    (sq_rem)
  );

  // Final root handed to the multiplier, optionally rounded to nearest.
`ifdef A_SQRT_B_ROUND_EN
  always_comb begin
    root_rnd = {1'b0, sq_root} + ROOT_W'(sq_rem > {{(B_W-SQ_W){1'b0}}, sq_root});
  end
`else
  logic unused_rem;
  assign unused_rem = ^sq_rem;

  always_comb begin
    root_rnd = {1'b0, sq_root};
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; in_ready only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_ready)  state_d = SQRT;
      SQRT:    if (last_sqrt) state_d = MUL;
      MUL:     if (last_mul)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Control decode from state and iteration counter.
  always_comb begin
    sq_start  = (state_q == IDLE) && in_ready;
    sq_step   = (state_q == SQRT);
    last_sqrt = (state_q == SQRT) && (cnt_q == CNT_W'(SQRT_CYC - 1));
    last_mul  = (state_q == MUL)  && (cnt_q == CNT_W'(MUL_CYC - 1));
  end

  // Shift-add: add the shifted multiplicand when the current root LSB is set.
  always_comb begin
    acc_nxt = acc_q + (root_q[0] ? mcand_q : '0);
  end

  // Datapath: operand capture, root hand-off, multiply and result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      root_q  <= '0;
      acc_q   <= '0;
      y_out   <= '0;
      y_ready <= 1'b0;
    end else begin
      y_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_ready) begin
            mcand_q <= ACC_W'(a_in);
            root_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        SQRT: begin
          if (last_sqrt) begin
            root_q <= root_rnd;
            cnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        MUL: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          root_q  <= root_q >> 1;
          if (last_mul) begin
            y_out   <= acc_nxt[Y_W-1:0];
            y_ready <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_a_sqrt_b.sv
// tb_a_sqrt_b: directed, table-driven bench for a_sqrt_b. Expected results
// are hand-computed for both the floor and the rounding build; the column
// used follows A_SQRT_B_ROUND_EN.
module tb_a_sqrt_b;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        in_ready;
  logic [11:0] y_out;
  logic        y_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] y_floor;
    logic [11:0] y_round;
  } vec_t;

  vec_t vecs [12];

  a_sqrt_b dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .in_ready (in_ready),
    .y_out    (y_out),
    .y_ready  (y_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] expect_y(input vec_t v);
`ifdef A_SQRT_B_ROUND_EN
    return v.y_round;
`else
    return v.y_floor;
`endif
  endfunction

  // Pulse in_ready for one edge (E0), then wait for y_ready. lat is the
  // number of edges after E0 at which y_ready was seen (0 = never).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [11:0] y, output int lat);
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    in_ready = 1'b1;
    @(posedge clk);
    #1 in_ready = 1'b0;
    lat = 0;
    y   = '0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (y_ready) begin
        lat = k;
        y   = y_out;
        break;
      end
    end
  endtask

  initial begin
    logic [11:0] y;
    int          lat;
    int          pulses;
    int          first_pulse;
    logic        hold_ok;

    //            a      b      floor    round
    vecs[0]  = '{8'h00, 8'h02, 12'h000, 12'h000};
    vecs[1]  = '{8'h19, 8'h1B, 12'h07D, 12'h07D};
    vecs[2]  = '{8'h64, 8'h66, 12'h3E8, 12'h3E8};
    vecs[3]  = '{8'hFA, 8'hFC, 12'hEA6, 12'hFA0};
    vecs[4]  = '{8'hFF, 8'hFF, 12'hEF1, 12'hFF0};
    vecs[5]  = '{8'hFF, 8'h00, 12'h000, 12'h000};
    vecs[6]  = '{8'h0A, 8'h03, 12'h00A, 12'h014};
    vecs[7]  = '{8'h07, 8'h0D, 12'h015, 12'h01C};
    vecs[8]  = '{8'h03, 8'h0C, 12'h009, 12'h009};
    vecs[9]  = '{8'h80, 8'h40, 12'h400, 12'h400};
    vecs[10] = '{8'h01, 8'h01, 12'h001, 12'h001};
    vecs[11] = '{8'h10, 8'hE1, 12'h0F0, 12'h0F0};

    rst      = 1'b1;
    in_ready = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset y_out", 16'(y_out), 16'h000);
    check("reset y_ready", 16'(y_ready), 16'h0);

    // Table vectors: result, 9-cycle latency, one-cycle strobe.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, y, lat);
      check($sformatf("vec%0d y", i), 16'(y), 16'(expect_y(vecs[i])));
      check($sformatf("vec%0d latency", i), 16'(lat), 16'd9);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d strobe width", i), 16'(y_ready), 16'h0);
    end

    // Busy: second start with new operands at E3 must be ignored.
    @(negedge clk);
    a_in = 8'h19; b_in = 8'h1B; in_ready = 1'b1;
    @(posedge clk);                        // E0
    #1 in_ready = 1'b0;
    @(posedge clk);                        // E1
    @(posedge clk);                        // E2
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; in_ready = 1'b1;
    @(posedge clk);                        // E3
    #1 in_ready = 1'b0;
    pulses = 0; first_pulse = 0; y = '0;
    for (int k = 4; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (y_ready) begin
        pulses++;
        if (first_pulse == 0) begin
          first_pulse = k;
          y = y_out;
        end
      end
    end
    check("busy y", 16'(y), 16'h07D);
    check("busy done edge", 16'(first_pulse), 16'd9);
    check("busy pulse count", 16'(pulses), 16'd1);

    // Reset at E5 aborts the operation: y_out cleared, no strobe.
    @(negedge clk);
    a_in = 8'hFF; b_in = 8'hFF; in_ready = 1'b1;
    @(posedge clk);                        // E0
    #1 in_ready = 1'b0;
    repeat (4) @(posedge clk);             // E1..E4
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);                        // E5
    #1 rst = 1'b0;
    check("abort y_out cleared", 16'(y_out), 16'h000);
    pulses = 0; hold_ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (y_ready) pulses++;
      if (y_out !== 12'h000) hold_ok = 1'b0;
    end
    check("abort pulse count", 16'(pulses), 16'd0);
    check("abort y_out stays 0", 16'(hold_ok), 16'h1);
    run_op(8'h64, 8'h66, y, lat);
    check("after abort y", 16'(y), 16'h3E8);
    check("after abort latency", 16'(lat), 16'd9);

    // Back-to-back: second start lands on E10 and completes at E19.
    run_op(8'h19, 8'h1B, y, lat);
    check("b2b first y", 16'(y), 16'h07D);
    run_op(8'h80, 8'h40, y, lat);
    check("b2b second y", 16'(y), 16'h400);
    check("b2b second latency", 16'(lat), 16'd9);

    // Hold: y_out stable and no strobe for 20 idle cycles.
    hold_ok = 1'b1; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (y_ready) pulses++;
      if (y_out !== 12'h400) hold_ok = 1'b0;
    end
    check("hold y_out stable", 16'(hold_ok), 16'h1);
    check("hold no strobe", 16'(pulses), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
